// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with request pacing, response buffer and redirect handling
//
// Purpose: owns the PC, issues in-order fetch requests to instruction memory,
// buffers returned words in a small FIFO and hands {inst, inst_addr} to decode.
// Redirects from exe flush the buffer and mark all in-flight fetches for discard.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_req_*          fetch request: valid/ready handshake, 64-bit word-aligned address
//   imem_resp_*         fetch response: valid + 32-bit word, in request order
//   redirect_valid/pc   taken branch/jump target from exe
//   id_valid/id_ready   decode handshake; inst/inst_addr are the buffer head
module if_stage #(
  parameter logic [63:0] PC_RESET   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_addr
);

  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  logic [63:0]   pc_q, pc_d;
  logic          pend_q, pend_d;
  logic [63:0]   pend_addr_q, pend_addr_d;
  logic          stale_q, stale_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] drop_q, drop_d;

  // Addresses of accepted requests, in issue order; popped by every response.
  logic [63:0]   tag_addr_q [FIFO_DEPTH];
  logic [63:0]   tag_addr_d [FIFO_DEPTH];
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic [63:0]   fifo_addr_q [FIFO_DEPTH];
  logic [63:0]   fifo_addr_d [FIFO_DEPTH];
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [CW-1:0] occ;
  logic          accept, resp_drop, resp_live, fifo_empty, pop;

  assign occ        = fifo_cnt_q + live_q + drop_q;
  // Gated by rst_n so the request line is quiet while reset is held.
  assign imem_req_valid = rst_n & ((occ < DEPTH_C) | pend_q);
  // A stalled request keeps its original address even across a redirect.
  assign imem_req_addr  = pend_q ? pend_addr_q : pc_q;
  assign accept     = imem_req_valid & imem_req_ready;
  // Discards always belong to the oldest in-flight fetches, so they are consumed first.
  assign resp_drop  = imem_resp_valid & (drop_q != '0);
  assign resp_live  = imem_resp_valid & (drop_q == '0) & (live_q != '0);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign id_valid   = ~fifo_empty & ~redirect_valid;
  assign pop        = id_valid & id_ready;
  assign inst       = fifo_empty ? NOP   : fifo_data_q[fifo_rd_q];
  assign inst_addr  = fifo_empty ? '0    : fifo_addr_q[fifo_rd_q];

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    stale_d     = stale_q;
    live_d      = live_q;
    drop_d      = drop_q;
    tag_addr_d  = tag_addr_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_cnt_d  = fifo_cnt_q;

    if (accept) begin
      tag_addr_d[tag_wr_q] = imem_req_addr;
      tag_wr_d = ptr_inc(tag_wr_q);
      pend_d   = 1'b0;
      if (stale_q) begin
        // The held pre-redirect request goes out; pc already points at the new target.
        drop_d  = drop_d + CW'(1);
        stale_d = 1'b0;
      end else begin
        live_d = live_d + CW'(1);
        pc_d   = pc_q + 64'd4;
      end
    end else if (imem_req_valid) begin
      pend_d      = 1'b1;
      pend_addr_d = imem_req_addr;
    end

    if (resp_drop | resp_live) tag_rd_d = ptr_inc(tag_rd_q);
    if (resp_drop) drop_d = drop_d - CW'(1);
    if (resp_live) begin
      live_d = live_d - CW'(1);
      fifo_data_d[fifo_wr_q] = imem_resp_data;
      fifo_addr_d[fifo_wr_q] = tag_addr_q[tag_rd_q];
      fifo_wr_d  = ptr_inc(fifo_wr_q);
      fifo_cnt_d = fifo_cnt_d + CW'(1);
    end
    if (pop) begin
      fifo_rd_d  = ptr_inc(fifo_rd_q);
      fifo_cnt_d = fifo_cnt_d - CW'(1);
    end

    if (redirect_valid) begin
      // Everything still in flight, including this cycle's accept, becomes a discard.
      drop_d     = drop_d + live_d;
      live_d     = '0;
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      pc_d       = redirect_pc & ~64'h3;
      if (imem_req_valid & ~imem_req_ready) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RESET;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stale_q     <= 1'b0;
      live_q      <= '0;
      drop_q      <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_addr_q[i]  <= '0;
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stale_q     <= stale_d;
      live_q      <= live_d;
      drop_q      <= drop_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_cnt_q  <= fifo_cnt_d;
      tag_addr_q  <= tag_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
    end
  end

endmodule
